cstream_capture: RTL
====================

# cstream_capture

Stream-sink capture buffer for packed complex I/Q samples: the write-to-memory counterpart of the memory-driven vector sources used to exercise the complex arithmetic blocks (cmul16 and relatives). It accepts the {I,Q} output stream of a DSP block, stores a burst into an internal RAM on command, and exposes a registered random-access readback port for a host or bench to drain results. It never back-pressures the upstream block.

## Interface
- DATA_WIDTH, 16, width of each I and Q component.
- AWIDTH, 14, buffer address width; DEPTH = 2^AWIDTH samples.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- arm  in  1  single-cycle pulse; starts a new capture.
- stop_on_last  in  1  when 1, capture ends after a beat with in_tlast=1; sampled on every beat.
- in_tdata  in  2*DATA_WIDTH  sample, I in [2*DW-1:DW], Q in [DW-1:0].
- in_tvalid  in  1  sample valid.
- in_tlast  in  1  end-of-packet marker.
- in_tready  out  1  always 1 out of reset.
- busy  out  1  1 while in CAPTURE.
- done  out  1  1 while in DONE.
- count  out  AWIDTH+1  samples stored in the current or last capture.
- drop_count  out  16  beats accepted while not capturing; saturates at 0xFFFF.
- rd_en  in  1  readback request.
- rd_addr  in  AWIDTH  readback address.
- rd_data  out  2*DATA_WIDTH  readback data.
- rd_valid  out  1  rd_data valid.

## Operation
- States: IDLE (reset state), CAPTURE, DONE.
- Beat = cycle with in_tvalid=1 (in_tready is always 1 out of reset).
- IDLE/DONE:
  - Beats are discarded and increment drop_count (saturating).
  - arm=1: count <= 0, write pointer <= 0, state -> CAPTURE.
  - A beat on the arm cycle is dropped and counted in drop_count.
- CAPTURE:
  - Each beat writes in_tdata to RAM[wr_ptr]; wr_ptr and count increment.
  - Exit to DONE after the beat that makes count = DEPTH (full), or after a beat with in_tlast=1 while stop_on_last=1.
  - When both exit conditions hit on the same beat: exit once, with count = DEPTH.
  - arm is ignored. Beats with in_tvalid=0 do nothing. in_tlast with stop_on_last=0 is ignored.
- count range is 0..DEPTH. wr_ptr wraps mod DEPTH but is never used past full.
- drop_count is not cleared by arm; only reset clears it.
- Readback is allowed in any state.
  - rd_data is the RAM word at rd_addr, registered.
  - Read/write collision on the same address in the same cycle returns the old contents (read-before-write).
  - Unwritten locations return undefined data.
- Reset mid-capture: state -> IDLE; busy, done, count, drop_count, rd_valid <= 0; rd_data <= 0. RAM contents are not cleared.

## Timing
- Reset values: in_tready=0 during reset, then 1 from the first cycle after reset deasserts. busy=0, done=0, count=0, drop_count=0, rd_valid=0, rd_data=0.
- arm at cycle N: busy=1 and count=0 at N+1. The first capturable beat is at N+1.
- Beat at cycle M in CAPTURE: count is incremented at M+1.
- Terminating beat at cycle M: busy=0 and done=1 at M+1, with the final count at M+1.
- Re-arm from DONE at cycle N: done=0 and busy=1 at N+1.
- Readback latency is 1 cycle: rd_en at cycle K gives rd_valid=1 and rd_data at K+1. rd_valid=0 otherwise.
- rd_data holds its value when rd_en=0.
- RAM is single-clock, one write port and one read port, and must map to block RAM.

## Test plan
- Use AWIDTH=4 (DEPTH=16) unless noted.
- Reset then idle: assert reset for 3 cycles. Check in_tready=0 during reset, then in_tready=1, busy=0, done=0, count=0, drop_count=0.
- Drops before arm: send 5 valid beats, then arm. Check drop_count=5 and busy=1 one cycle after arm.
- Fill to full: arm, then 20 continuous beats with in_tdata = {i, ~i}, i = 0..19, stop_on_last=0. Check done=1 one cycle after beat 15, count=16, drop_count=4. Read addresses 0..15 and check RAM[k] = {k, ~k} with rd_valid one cycle after each rd_en.
- tlast stop with gaps: arm, stop_on_last=1, send 6 beats with idle cycles between them, in_tlast on beat 6 (0x00060006). Check count=6, done=1, RAM[5]=0x00060006. Repeat with stop_on_last=0 and check capture continues to count=16.
- Simultaneous full + tlast: arm, send 16 beats with in_tlast on beat 16 and stop_on_last=1. Check a single DONE entry, count=16, and no drop counted for beat 16.
- Reset mid-capture and collision: arm, send 3 beats, reset. Check IDLE, count=0, busy=0. Then re-arm, read addr 0 while writing addr 0: rd_data must equal the old value from the previous capture.

Source files
------------

// File: rtl/cstream_capture.sv
`default_nettype none
// ============================================================================
//  Module   : cstream_capture
//  Purpose  : Stream-sink capture buffer for packed complex {I,Q} samples.
//             Discards beats until armed, then stores a burst into an
//             internal single-clock RAM until the buffer is full or, when
//             stop_on_last is set, until a beat carrying in_tlast. Beats seen
//             while not capturing are counted in a saturating drop counter.
//             A registered random-access read port drains the buffer in any
//             state. The upstream block is never back-pressured.
//
//  Ports    : clk, reset         clock, synchronous active-high reset
//             arm                one-cycle pulse, starts a new capture
//             stop_on_last       end capture on a beat with in_tlast=1
//             in_tdata/tvalid/tlast/tready   input stream (I high, Q low)
//             busy / done        capture in progress / capture finished
//             count              samples stored in current or last capture
//             drop_count         beats seen while not capturing (saturating)
//             rd_en/rd_addr      readback request and address
//             rd_data/rd_valid   readback data, one cycle after rd_en
//
//  Revision : 1.0  initial release
// ============================================================================
module cstream_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int AWIDTH     = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    stop_on_last,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    output logic                    busy,
    output logic                    done,
    output logic [AWIDTH:0]         count,
    output logic [15:0]             drop_count,
    input  logic                    rd_en,
    input  logic [AWIDTH-1:0]       rd_addr,
    output logic [2*DATA_WIDTH-1:0] rd_data,
    output logic                    rd_valid
);

    localparam int              c_DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] c_FULL     = (AWIDTH+1)'(c_DEPTH);
    localparam logic [AWIDTH:0] c_LAST     = c_FULL - 1'b1;
    localparam logic [15:0]     c_DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_ready;
    logic [AWIDTH:0]         r_count;
    logic [AWIDTH-1:0]       r_wr_ptr;
    logic [15:0]             r_drop_count;
    logic [2*DATA_WIDTH-1:0] r_rd_data;
    logic                    r_rd_valid;
    logic [2*DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                    w_beat;
    logic                    w_capturing;
    logic                    w_wr_en;

    // Beats are suppressed while reset is held so a capture interrupted by
    // reset cannot sneak one more write into the RAM on the reset edge.
    assign w_beat      = in_tvalid & r_ready & ~reset;
    assign w_capturing = (r_state == ST_CAPTURE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_beat) begin
                    w_wr_en = 1'b1;
                    // Full and tlast on the same beat both land in DONE
                    // through this single transition.
                    if ((r_count == c_LAST) || (in_tlast && stop_on_last)) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Ready, counters and write pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready      <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_drop_count <= '0;
        end else begin
            r_ready <= 1'b1;

            if (!w_capturing && arm) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
            end else if (w_wr_en) begin
                r_count  <= r_count + 1'b1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            // A beat on the arm cycle still belongs to the idle window.
            if (!w_capturing && w_beat && (r_drop_count != c_DROP_MAX)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture RAM: one write port, one registered read port. Kept free of
    // reset so it maps onto block RAM; the nonblocking read of the old word
    // gives read-before-write on an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_mem[rd_addr];
            end
        end
    end

    assign in_tready  = r_ready;
    assign busy       = (r_state == ST_CAPTURE);
    assign done       = (r_state == ST_DONE);
    assign count      = r_count;
    assign drop_count = r_drop_count;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;

endmodule
`default_nettype wire
